writeback_arbiter: RTL and testbench

- Parametrised N-channel writeback stage between the execution units (FX, LdSt, FP, Branch, Trap) and the register-file write ports.
- Each unit pushes writeback packets through a valid/ready handshake into its own small FIFO.
- A round-robin arbiter drains at most one packet per cycle into registered dual-port writeback outputs.
- No packet is lost when several units complete in the same cycle, and no unit can starve another.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/writeback_arbiter_if.sv | 49 ++++
 rtl/wb_channel_fifo.sv | 60 ++++++
 rtl/writeback_arbiter.sv | 152 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants, default widths and packet layout for the writeback stage.
package wb_pkg;

    localparam int unsigned DEF_NUM_UNITS   = 3;
    localparam int unsigned DEF_UNIT_CODE_W = 3;
    localparam int unsigned DEF_REG_ADDR_W  = 6;
    localparam int unsigned DEF_DATA_W      = 64;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;

    // Functional-unit codes.
    localparam logic [DEF_UNIT_CODE_W-1:0] FX     = 3'd0;
    localparam logic [DEF_UNIT_CODE_W-1:0] FP     = 3'd1;
    localparam logic [DEF_UNIT_CODE_W-1:0] LDST   = 3'd2;
    localparam logic [DEF_UNIT_CODE_W-1:0] BRANCH = 3'd3;
    localparam logic [DEF_UNIT_CODE_W-1:0] TRAP   = 3'd4;

    // Writeback packet at the default widths.
    typedef struct packed {
        logic [DEF_UNIT_CODE_W-1:0] code;
        logic                       wb1_en;
        logic [DEF_REG_ADDR_W-1:0]  wb1_addr;
        logic [DEF_DATA_W-1:0]      wb1_data;
        logic                       wb2_en;
        logic [DEF_REG_ADDR_W-1:0]  wb2_addr;
        logic [DEF_DATA_W-1:0]      wb2_data;
    } wb_pkt_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Execution-unit input channels and register-file writeback outputs.
interface writeback_arbiter_if
    import wb_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = DEF_NUM_UNITS,
    parameter int unsigned UNIT_CODE_W = DEF_UNIT_CODE_W,
    parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W
);

    logic [NUM_UNITS-1:0]             unit_valid_i;
    logic [NUM_UNITS-1:0]             unit_ready_o;
    logic [NUM_UNITS*UNIT_CODE_W-1:0] unit_code_i;
    logic [NUM_UNITS-1:0]             unit_wb1_en_i;
    logic [NUM_UNITS-1:0]             unit_wb2_en_i;
    logic [NUM_UNITS*REG_ADDR_W-1:0]  unit_wb1_addr_i;
    logic [NUM_UNITS*REG_ADDR_W-1:0]  unit_wb2_addr_i;
    logic [NUM_UNITS*DATA_W-1:0]      unit_wb1_data_i;
    logic [NUM_UNITS*DATA_W-1:0]      unit_wb2_data_i;

    logic                   wb_valid_o;
    logic [UNIT_CODE_W-1:0] wb_unit_code_o;
    logic                   wb1_en_o;
    logic                   wb2_en_o;
    logic [REG_ADDR_W-1:0]  wb1_addr_o;
    logic [REG_ADDR_W-1:0]  wb2_addr_o;
    logic [DATA_W-1:0]      wb1_data_o;
    logic [DATA_W-1:0]      wb2_data_o;
    logic                   fifo_overflow_o;

    // Arbiter side.
    modport slave (
        input  unit_valid_i, unit_code_i, unit_wb1_en_i, unit_wb2_en_i,
        input  unit_wb1_addr_i, unit_wb2_addr_i, unit_wb1_data_i, unit_wb2_data_i,
        output unit_ready_o,
        output wb_valid_o, wb_unit_code_o, wb1_en_o, wb2_en_o,
        output wb1_addr_o, wb2_addr_o, wb1_data_o, wb2_data_o, fifo_overflow_o
    );

    // Execution units and register-file side.
    modport master (
        output unit_valid_i, unit_code_i, unit_wb1_en_i, unit_wb2_en_i,
        output unit_wb1_addr_i, unit_wb2_addr_i, unit_wb1_data_i, unit_wb2_data_i,
        input  unit_ready_o,
        input  wb_valid_o, wb_unit_code_o, wb1_en_o, wb2_en_o,
        input  wb1_addr_o, wb2_addr_o, wb1_data_o, wb2_data_o, fifo_overflow_o
    );

endinterface

// File: rtl/wb_channel_fifo.sv
// Per-unit synchronous FIFO with sticky overflow detect. A full FIFO refuses
// a push even when it is popped in the same cycle.
module wb_channel_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign data_o     = mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (push_i && full_o) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// N-channel writeback stage: per-unit FIFOs drained round-robin, one packet
// per cycle, into registered dual-port register-file writeback outputs.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = DEF_NUM_UNITS,
    parameter int unsigned UNIT_CODE_W = DEF_UNIT_CODE_W,
    parameter int unsigned REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input logic                clock_i,
    input logic                reset_i,
    writeback_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(NUM_UNITS);

    typedef struct packed {
        logic [UNIT_CODE_W-1:0] code;
        logic                   wb1_en;
        logic [REG_ADDR_W-1:0]  wb1_addr;
        logic [DATA_W-1:0]      wb1_data;
        logic                   wb2_en;
        logic [REG_ADDR_W-1:0]  wb2_addr;
        logic [DATA_W-1:0]      wb2_data;
    } pkt_t;

    localparam int unsigned PKT_W = $bits(pkt_t);

    logic [NUM_UNITS-1:0]            ready;
    logic [NUM_UNITS-1:0]            push;
    logic [NUM_UNITS-1:0]            pop;
    logic [NUM_UNITS-1:0]            full;
    logic [NUM_UNITS-1:0]            empty;
    logic [NUM_UNITS-1:0]            overflow;
    logic [NUM_UNITS-1:0][PKT_W-1:0] heads;

    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] rr_q;
    logic [PTR_W-1:0] rr_d;
    int               cand;
    pkt_t             grant_pkt;

    logic                   valid_q;
    logic [UNIT_CODE_W-1:0] code_q;
    logic                   wb1_en_q;
    logic                   wb2_en_q;
    logic [REG_ADDR_W-1:0]  wb1_addr_q;
    logic [REG_ADDR_W-1:0]  wb2_addr_q;
    logic [DATA_W-1:0]      wb1_data_q;
    logic [DATA_W-1:0]      wb2_data_q;

    // Ready comes only from registered occupancy; null packets are accepted but not stored.
    assign ready = reset_i ? '0 : ~full;
    assign push  = bus.unit_valid_i & ready & (bus.unit_wb1_en_i | bus.unit_wb2_en_i);

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_chan
        logic chan_push;
        pkt_t chan_in;

        assign chan_push = push[u];
        assign chan_in   = '{
            code:     bus.unit_code_i[u*UNIT_CODE_W +: UNIT_CODE_W],
            wb1_en:   bus.unit_wb1_en_i[u],
            wb1_addr: bus.unit_wb1_addr_i[u*REG_ADDR_W +: REG_ADDR_W],
            wb1_data: bus.unit_wb1_data_i[u*DATA_W +: DATA_W],
            wb2_en:   bus.unit_wb2_en_i[u],
            wb2_addr: bus.unit_wb2_addr_i[u*REG_ADDR_W +: REG_ADDR_W],
            wb2_data: bus.unit_wb2_data_i[u*DATA_W +: DATA_W]
        };

        wb_channel_fifo #(
            .WIDTH (PKT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock_i    (clock_i),
            .reset_i    (reset_i),
            .push_i     (chan_push),
            .pop_i      (pop[u]),
            .data_i     (chan_in),
            .data_o     (heads[u]),
            .full_o     (full[u]),
            .empty_o    (empty[u]),
            .overflow_o (overflow[u])
        );
    end

    // Round-robin search from rr_q upwards with wrap; scanning offsets high to low
    // leaves the nearest non-empty channel as the grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            cand = int'(rr_q) + i;
            if (cand >= int'(NUM_UNITS)) cand = cand - int'(NUM_UNITS);
            if (!empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
        pop = '0;
        if (grant_valid) pop[grant_idx] = 1'b1;
        rr_d = rr_q;
        if (grant_valid) begin
            rr_d = (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    assign grant_pkt = heads[grant_idx];

    // Pointer and output registers; address/data/code hold when nothing is granted.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rr_q       <= '0;
            valid_q    <= 1'b0;
            code_q     <= '0;
            wb1_en_q   <= 1'b0;
            wb2_en_q   <= 1'b0;
            wb1_addr_q <= '0;
            wb2_addr_q <= '0;
            wb1_data_q <= '0;
            wb2_data_q <= '0;
        end else begin
            rr_q     <= rr_d;
            valid_q  <= grant_valid;
            wb1_en_q <= grant_valid && grant_pkt.wb1_en;
            wb2_en_q <= grant_valid && grant_pkt.wb2_en;
            if (grant_valid) begin
                code_q     <= grant_pkt.code;
                wb1_addr_q <= grant_pkt.wb1_addr;
                wb2_addr_q <= grant_pkt.wb2_addr;
                wb1_data_q <= grant_pkt.wb1_data;
                wb2_data_q <= grant_pkt.wb2_data;
            end
        end
    end

    assign bus.unit_ready_o    = ready;
    assign bus.wb_valid_o      = valid_q;
    assign bus.wb_unit_code_o  = code_q;
    assign bus.wb1_en_o        = wb1_en_q;
    assign bus.wb2_en_o        = wb2_en_q;
    assign bus.wb1_addr_o      = wb1_addr_q;
    assign bus.wb2_addr_o      = wb2_addr_q;
    assign bus.wb1_data_o      = wb1_data_q;
    assign bus.wb2_data_o      = wb2_data_q;
    assign bus.fifo_overflow_o = |overflow;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: expected packets are queued when a
// unit handshake completes and retired when the matching unit's packet shows
// up on the writeback outputs.
module tb_writeback_arbiter;
    import wb_pkg::*;

    localparam int unsigned NU = 3;
    localparam int unsigned CW = 3;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 64;
    localparam int unsigned FD = 4;

    logic clock;
    logic reset;

    writeback_arbiter_if #(
        .NUM_UNITS   (NU),
        .UNIT_CODE_W (CW),
        .REG_ADDR_W  (AW),
        .DATA_W      (DW)
    ) bus ();

    writeback_arbiter #(
        .NUM_UNITS   (NU),
        .UNIT_CODE_W (CW),
        .REG_ADDR_W  (AW),
        .DATA_W      (DW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_errors = 0;
    wb_pkt_t      sb_q[$];
    int           pushed[NU];
    logic [CW-1:0] unit_code[NU];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Retire the oldest expected packet of the unit whose code appears on the outputs.
    task automatic mon_check();
        int idx = -1;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (idx < 0 && sb_q[i].code == bus.wb_unit_code_o) idx = i;
        end
        check("sb_expected", (idx >= 0), 1);
        if (idx >= 0) begin
            check("sb_wb1_en",   bus.wb1_en_o,   sb_q[idx].wb1_en);
            check("sb_wb1_addr", bus.wb1_addr_o, sb_q[idx].wb1_addr);
            check("sb_wb1_data", bus.wb1_data_o, sb_q[idx].wb1_data);
            check("sb_wb2_en",   bus.wb2_en_o,   sb_q[idx].wb2_en);
            check("sb_wb2_addr", bus.wb2_addr_o, sb_q[idx].wb2_addr);
            check("sb_wb2_data", bus.wb2_data_o, sb_q[idx].wb2_data);
            sb_q.delete(idx);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && bus.wb_valid_o) mon_check();
    end

    function automatic wb_pkt_t mk_pkt(input int u, input int seq);
        wb_pkt_t p;
        p.code     = unit_code[u];
        p.wb1_en   = 1'b1;
        p.wb1_addr = 6'($urandom_range(1, 63));
        p.wb1_data = {8'(u), 24'(seq), 32'($urandom)};
        p.wb2_en   = 1'($urandom);
        p.wb2_addr = 6'($urandom_range(0, 63));
        p.wb2_data = {32'($urandom), 32'($urandom)};
        return p;
    endfunction

    task automatic drive_unit(input int u, input wb_pkt_t p);
        bus.unit_code_i[u*CW +: CW]     = p.code;
        bus.unit_wb1_en_i[u]            = p.wb1_en;
        bus.unit_wb1_addr_i[u*AW +: AW] = p.wb1_addr;
        bus.unit_wb1_data_i[u*DW +: DW] = p.wb1_data;
        bus.unit_wb2_en_i[u]            = p.wb2_en;
        bus.unit_wb2_addr_i[u*AW +: AW] = p.wb2_addr;
        bus.unit_wb2_data_i[u*DW +: DW] = p.wb2_data;
    endtask

    // Present a packet and hold it until an edge sees valid && ready.
    task automatic send(input int u, input wb_pkt_t p);
        bit accepted = 1'b0;
        drive_unit(u, p);
        bus.unit_valid_i[u] = 1'b1;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clock);
            if (bus.unit_ready_o[u] && !reset) accepted = 1'b1;
            @(posedge clock);
            #1;
        end
        bus.unit_valid_i[u] = 1'b0;
        check("send_accepted", accepted, 1);
        if (accepted) begin
            pushed[u]++;
            if (p.wb1_en || p.wb2_en) sb_q.push_back(p);
        end
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_valid"},  bus.wb_valid_o, 0);
        check({pfx, "_code"},   bus.wb_unit_code_o, 0);
        check({pfx, "_wb1_en"}, bus.wb1_en_o, 0);
        check({pfx, "_wb2_en"}, bus.wb2_en_o, 0);
        check({pfx, "_addr1"},  bus.wb1_addr_o, 0);
        check({pfx, "_addr2"},  bus.wb2_addr_o, 0);
        check({pfx, "_data1"},  bus.wb1_data_o, 0);
        check({pfx, "_data2"},  bus.wb2_data_o, 0);
        check({pfx, "_ovf"},    bus.fifo_overflow_o, 0);
        check({pfx, "_ready"},  bus.unit_ready_o, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb_q.delete();
        @(posedge clock);
        #1;
        check_zero_outputs("rst");
        reset = 1'b0;
        #1;
        check("rst_release_ready", bus.unit_ready_o, 3'b111);
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && sb_q.size() != 0; c++) @(posedge clock);
        repeat (2) @(posedge clock);
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    // Unit 0 and unit 1 both stream: grants must alternate and unit 1 fills at depth.
    task automatic observe_t3();
        int prev = -1;
        int delivered1 = 0;
        int base1 = pushed[1];
        bit seen_full = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            if (bus.wb_valid_o) begin
                if (prev >= 0) check("t3_alternate", (int'(bus.wb_unit_code_o) != prev), 1);
                prev = int'(bus.wb_unit_code_o);
                if (bus.wb_unit_code_o == FP) delivered1++;
            end
            if (!seen_full && !bus.unit_ready_o[1]) begin
                seen_full = 1'b1;
                check("t3_full_depth", (pushed[1] - base1) - delivered1, FD);
            end
        end
        check("t3_ready1_dropped", seen_full, 1);
    endtask

    // When unit 2 is refused, inject a push behind the handshake into the full FIFO.
    task automatic observe_t4();
        bit hit = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge clock);
            if (bus.unit_valid_i[2] && !bus.unit_ready_o[2]) begin
                hit = 1'b1;
                check("t4_refused_no_ovf", bus.fifo_overflow_o, 0);
                force dut.g_chan[2].chan_push = 1'b1;
                @(posedge clock);
                #1;
                release dut.g_chan[2].chan_push;
                check("t4_bypass_ovf", bus.fifo_overflow_o, 1);
            end
        end
        check("t4_full_seen", hit, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_pkt_t p;
        unit_code[0] = FX;
        unit_code[1] = FP;
        unit_code[2] = LDST;
        for (int u = 0; u < NU; u++) pushed[u] = 0;
        reset                = 1'b1;
        bus.unit_valid_i     = '0;
        bus.unit_code_i      = '0;
        bus.unit_wb1_en_i    = '0;
        bus.unit_wb2_en_i    = '0;
        bus.unit_wb1_addr_i  = '0;
        bus.unit_wb2_addr_i  = '0;
        bus.unit_wb1_data_i  = '0;
        bus.unit_wb2_data_i  = '0;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // 1: single packet, latency and one-cycle valid.
        p          = '0;
        p.code     = FX;
        p.wb1_en   = 1'b1;
        p.wb1_addr = 6'd5;
        p.wb1_data = 64'h1234;
        send(0, p);
        @(posedge clock);
        #1;
        check("t1_valid", bus.wb_valid_o, 1);
        check("t1_code", bus.wb_unit_code_o, FX);
        check("t1_addr", bus.wb1_addr_o, 5);
        check("t1_data", bus.wb1_data_o, 64'h1234);
        check("t1_wb2_en", bus.wb2_en_o, 0);
        @(posedge clock);
        #1;
        check("t1_valid_drop", bus.wb_valid_o, 0);
        check("t1_en_drop", bus.wb1_en_o, 0);
        check("t1_addr_hold", bus.wb1_addr_o, 5);

        // 2: three simultaneous pushes drain 0,1,2; pointer wraps back to 0.
        do_reset();
        fork
            send(0, mk_pkt(0, 100));
            send(1, mk_pkt(1, 100));
            send(2, mk_pkt(2, 100));
        join
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("t2_valid", bus.wb_valid_o, 1);
            check("t2_order", bus.wb_unit_code_o, unit_code[i]);
        end
        fork
            send(1, mk_pkt(1, 101));
            send(0, mk_pkt(0, 101));
        join
        @(posedge clock);
        #1;
        check("t2_rr_wrap_first", bus.wb_unit_code_o, FX);
        @(posedge clock);
        #1;
        check("t2_rr_wrap_second", bus.wb_unit_code_o, FP);
        drain();

        // 3: fairness under sustained traffic from two units.
        fork
            begin
                for (int s = 0; s < 12; s++) send(0, mk_pkt(0, 200 + s));
            end
            begin
                for (int s = 0; s < 12; s++) send(1, mk_pkt(1, 200 + s));
            end
            observe_t3();
        join
        drain();

        // 4: full-FIFO refusal and overflow from a push that skips the handshake.
        fork
            begin
                for (int s = 0; s < 8; s++) send(0, mk_pkt(0, 300 + s));
            end
            begin
                for (int s = 0; s < 8; s++) send(1, mk_pkt(1, 300 + s));
            end
            begin
                for (int s = 0; s < 8; s++) send(2, mk_pkt(2, 300 + s));
            end
            observe_t4();
        join
        drain();
        check("t4_ovf_sticky", bus.fifo_overflow_o, 1);

        // 5: null packet is accepted and never delivered.
        do_reset();
        p      = mk_pkt(0, 400);
        p.wb1_en = 1'b0;
        p.wb2_en = 1'b0;
        send(0, p);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            check("t5_no_valid", bus.wb_valid_o, 0);
        end

        // 6: reset with three packets queued discards them all.
        fork
            send(0, mk_pkt(0, 500));
            send(1, mk_pkt(1, 500));
            send(2, mk_pkt(2, 500));
        join
        reset = 1'b1;
        sb_q.delete();
        @(posedge clock);
        #1;
        check_zero_outputs("t6");
        reset = 1'b0;
        #1;
        check("t6_ready_all", bus.unit_ready_o, 3'b111);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            check("t6_no_stale", bus.wb_valid_o, 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
